// File: rtl/pixel_scheduler_pkg.sv
// Shared types and default geometry for the Mandelbrot pixel scheduler and the
// raster cursor it drives.
package pixel_scheduler_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_e;

    localparam int DEF_NUM_ENGINES   = 4;
    localparam int DEF_SCREEN_WIDTH  = 960;
    localparam int DEF_SCREEN_HEIGHT = 720;
    localparam int DEF_COORD_W       = 11;
    localparam int DEF_DEPTH_W       = 10;

endpackage

// File: rtl/pixel_scheduler_raster_cursor.sv
// Raster-order x/y walker: steps one pixel per advance and wraps to (0,0) at
// the end of a frame so frames follow each other with no gap.
module pixel_scheduler_raster_cursor
    import pixel_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int COORD_W       = DEF_COORD_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               advance_i,
    output logic [COORD_W-1:0] cx_o,
    output logic [COORD_W-1:0] cy_o,
    output logic               sof_o,
    output logic               eol_o
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT - 1);

    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               last_px;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign eol_o   = (cx_q == X_LAST);
    assign last_px = eol_o && (cy_q == Y_LAST);
    assign sof_o   = (cx_q == '0) && (cy_q == '0);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (advance_i) begin
            if (last_px) begin
                cx_d = '0;
                cy_d = '0;
            end else if (eol_o) begin
                cx_d = '0;
                cy_d = cy_q + COORD_W'(1);
            end else begin
                cx_d = cx_q + COORD_W'(1);
            end
        end
    end

    assign cx_o = cx_q;
    assign cy_o = cy_q;

endmodule

// File: rtl/pixel_scheduler.sv
// Round-robin dispatcher of raster pixels to iteration engines, with an
// in-order collector that re-serialises engine depths onto a valid/ready stream.
module pixel_scheduler
    import pixel_scheduler_pkg::*;
#(
    parameter int NUM_ENGINES   = DEF_NUM_ENGINES,
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int COORD_W       = DEF_COORD_W,
    parameter int DEPTH_W       = DEF_DEPTH_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_x,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DEPTH_W-1:0]             out_depth,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_ENGINES);

    // Output stream: out_valid is asserted while the slot at r_ptr holds a
    // captured depth; the pixel is consumed on any cycle with out_valid && out_ready,
    // and out_depth/out_sof/out_eol stay unchanged until that happens.
    slot_state_e        slot_q  [NUM_ENGINES];
    slot_state_e        slot_d  [NUM_ENGINES];
    logic [DEPTH_W-1:0] depth_q [NUM_ENGINES];
    logic [DEPTH_W-1:0] depth_d [NUM_ENGINES];
    logic [COORD_W-1:0] x_q     [NUM_ENGINES];
    logic [COORD_W-1:0] x_d     [NUM_ENGINES];
    logic [COORD_W-1:0] y_q     [NUM_ENGINES];
    logic [COORD_W-1:0] y_d     [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] sof_q, sof_d;
    logic [NUM_ENGINES-1:0] eol_q, eol_d;
    logic [NUM_ENGINES-1:0] start_q, start_d;
    logic [PTR_W-1:0]       d_ptr_q, d_ptr_d;
    logic [PTR_W-1:0]       r_ptr_q, r_ptr_d;

    logic               dispatch;
    logic               retire;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               cur_sof;
    logic               cur_eol;

    pixel_scheduler_raster_cursor #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT),
        .COORD_W      (COORD_W)
    ) u_cursor (
        .clk_i    (clk),
        .rst_i    (reset),
        .advance_i(dispatch),
        .cx_o     (cur_x),
        .cy_o     (cur_y),
        .sof_o    (cur_sof),
        .eol_o    (cur_eol)
    );

    assign dispatch  = run && (slot_q[d_ptr_q] == SLOT_IDLE);
    assign out_valid = (slot_q[r_ptr_q] == SLOT_DONE);
    assign retire    = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_q[i]  <= SLOT_IDLE;
                depth_q[i] <= '0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
            sof_q   <= '0;
            eol_q   <= '0;
            start_q <= '0;
            d_ptr_q <= '0;
            r_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_q[i]  <= slot_d[i];
                depth_q[i] <= depth_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            start_q <= start_d;
            d_ptr_q <= d_ptr_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    // Dispatch needs an IDLE slot and retire a DONE one, so the two can never
    // touch the same slot in one cycle; a freshly retired slot is next usable
    // only on the following cycle.
    always_comb begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            slot_d[i]  = slot_q[i];
            depth_d[i] = depth_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
        end
        sof_d   = sof_q;
        eol_d   = eol_q;
        start_d = '0;
        d_ptr_d = d_ptr_q;
        r_ptr_d = r_ptr_q;

        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (eng_done[i] && (slot_q[i] == SLOT_BUSY)) begin
                slot_d[i]  = SLOT_DONE;
                depth_d[i] = eng_depth[i*DEPTH_W +: DEPTH_W];
            end
        end

        if (dispatch) begin
            slot_d[d_ptr_q]  = SLOT_BUSY;
            x_d[d_ptr_q]     = cur_x;
            y_d[d_ptr_q]     = cur_y;
            sof_d[d_ptr_q]   = cur_sof;
            eol_d[d_ptr_q]   = cur_eol;
            start_d[d_ptr_q] = 1'b1;
            d_ptr_d          = d_ptr_q + PTR_W'(1);
        end

        if (retire) begin
            slot_d[r_ptr_q] = SLOT_IDLE;
            r_ptr_d         = r_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_x[i*COORD_W +: COORD_W] = x_q[i];
            eng_y[i*COORD_W +: COORD_W] = y_q[i];
            if (slot_q[i] != SLOT_IDLE) begin
                busy = 1'b1;
            end
        end
    end

    assign eng_start = start_q;
    assign out_depth = out_valid ? depth_q[r_ptr_q] : '0;
    assign out_sof   = out_valid && sof_q[r_ptr_q];
    assign out_eol   = out_valid && eol_q[r_ptr_q];

endmodule
